// File: rtl/dds_ui_pkg.sv
// Shared types and constants for the DDS front-panel decimal entry.
// Optional debounce is enabled with DEC_INPUT_DEBOUNCE_EN.
package dds_ui_pkg;

   typedef logic [3:0] bcd_t;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      CONVERT = 1'b1
   } dec_in_state_t;

   localparam bcd_t BCD_MAX = 4'd9;
   localparam int DEC_BASE = 10;

endpackage

// File: rtl/dec_input_btn_conditioner.sv
// Pushbutton synchroniser, optional debounce and rising-edge pulse.
// Debounce is built only when DEC_INPUT_DEBOUNCE_EN is defined.
module btn_conditioner
`ifdef DEC_INPUT_DEBOUNCE_EN
   #(parameter int DEBOUNCE_CYC = 250000)
`endif
   (
   input  logic clk,
   input  logic clr,
   input  logic btn,
   output logic pulse
);

   logic s1, s2, lvl, lvl_d;

   always_ff @(posedge clk) begin
      if (clr) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= btn;
         s2 <= s1;
      end
   end

`ifdef DEC_INPUT_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYC + 1);
   logic [CW-1:0] cnt;

   // lvl only follows s2 after DEBOUNCE_CYC consecutive differing samples
   always_ff @(posedge clk) begin
      if (clr) begin
         lvl <= 1'b0;
         cnt <= '0;
      end else if (s2 == lvl) begin
         cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
         lvl <= s2;
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end
`else
   assign lvl = s2;
`endif

   always_ff @(posedge clk) begin
      if (clr) lvl_d <= 1'b0;
      else     lvl_d <= lvl;
   end

   assign pulse = lvl & ~lvl_d;

endmodule

// File: rtl/dec_input.sv
// Front-panel BCD digit entry with sequential BCD->binary commit.
// Define DEC_INPUT_DEBOUNCE_EN to debounce the pushbuttons.
module dec_input
   import dds_ui_pkg::*;
#(
   parameter int DIGITS       = 4,
   parameter int WIDTH        = 16,
   parameter int DEBOUNCE_CYC = 250000
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  btn_sel,
   input  logic                  btn_up,
   input  logic                  btn_dn,
   input  logic                  btn_commit,
   output logic [WIDTH-1:0]      dec,
   output logic                  dec_valid,
   output logic                  busy,
   output logic [1:0]            cursor,
   output logic [4*DIGITS-1:0]   digits
);

   localparam int CNW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   if (DIGITS < 1 || DIGITS > 4 || DEBOUNCE_CYC < 1) begin : g_bad_cfg
      $error("dec_input: unsupported parameter set");
   end

   logic ev_sel, ev_up, ev_dn, ev_commit;
   logic [3:0] btns, evs;

   assign btns = {btn_commit, btn_dn, btn_up, btn_sel};
   assign {ev_commit, ev_dn, ev_up, ev_sel} = evs;

   for (genvar b = 0; b < 4; b++) begin : g_btn
      btn_conditioner
`ifdef DEC_INPUT_DEBOUNCE_EN
         #(.DEBOUNCE_CYC(DEBOUNCE_CYC))
`endif
         u_btn (
         .clk   (clk),
         .clr   (clr),
         .btn   (btns[b]),
         .pulse (evs[b])
      );
   end

   dec_in_state_t     state;
   bcd_t              dig [DIGITS];
   logic [4*DIGITS-1:0] shreg;
   logic [WIDTH-1:0]  acc, acc_next;
   logic [CNW-1:0]    cnt;

   for (genvar i = 0; i < DIGITS; i++) begin : g_dig
      assign digits[4*i +: 4] = dig[i];
   end

   // One event per cycle, commit > sel > up/dn; up+dn together cancel
   logic do_commit, do_sel, do_up, do_dn;
   assign do_commit = ev_commit;
   assign do_sel    = ~ev_commit & ev_sel;
   assign do_up     = ~ev_commit & ~ev_sel & ev_up & ~ev_dn;
   assign do_dn     = ~ev_commit & ~ev_sel & ev_dn & ~ev_up;

   assign acc_next = (acc << 3) + (acc << 1)
                   + WIDTH'(shreg[4*DIGITS-1 -: 4]);

   always_ff @(posedge clk) begin
      if (clr) begin
         state     <= IDLE;
         dec       <= '0;
         dec_valid <= 1'b0;
         busy      <= 1'b0;
         cursor    <= '0;
         shreg     <= '0;
         acc       <= '0;
         cnt       <= '0;
         for (int i = 0; i < DIGITS; i++) dig[i] <= '0;
      end else begin
         dec_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               unique case (1'b1)
                  do_commit: begin
                     shreg <= digits;
                     acc   <= '0;
                     cnt   <= '0;
                     busy  <= 1'b1;
                     state <= CONVERT;
                  end
                  do_sel: begin
                     cursor <= (cursor == 2'(DIGITS - 1))
                             ? 2'd0 : cursor + 2'd1;
                  end
                  do_up: begin
                     for (int i = 0; i < DIGITS; i++)
                        if (cursor == 2'(i))
                           dig[i] <= (dig[i] == BCD_MAX)
                                   ? 4'd0 : dig[i] + 4'd1;
                  end
                  do_dn: begin
                     for (int i = 0; i < DIGITS; i++)
                        if (cursor == 2'(i))
                           dig[i] <= (dig[i] == 4'd0)
                                   ? BCD_MAX : dig[i] - 4'd1;
                  end
                  default: ;
               endcase
            end
            CONVERT: begin
               acc   <= acc_next;
               shreg <= shreg << 4;
               cnt   <= cnt + 1'b1;
               if (cnt == CNW'(DIGITS - 1)) begin
                  dec       <= acc_next;
                  dec_valid <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
